// File: rtl/wb_merge_unit.sv
// Writeback merge: pipeline result (wb_sel/load extraction) and a FIFO-buffered long-latency
// result share one registered register-file write port. Optional: WB_LL_BYPASS_EN.
module wb_merge_unit #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned Q_DEPTH = 4,
   parameter int unsigned PTR_W   = $clog2(Q_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_wb,
   input  logic [XLEN-1:0]   pc_wb,
   input  logic [31:0]       inst_wb,
   input  logic [1:0]        wb_sel,
   input  logic [XLEN-1:0]   data_in_wb,
   input  logic [XLEN-1:0]   alu_result_wb,
   input  logic [2:0]        memdata_width,
   input  logic              ll_valid,
   output logic              ll_ready,
   input  logic [4:0]        ll_rd,
   input  logic [XLEN-1:0]   ll_data,
   output logic              rf_we,
   output logic [4:0]        rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              rf_src,
   output logic [PTR_W:0]    q_count
);

   localparam int unsigned OFF_W = $clog2(XLEN / 8);

   logic [4:0]      rd;
   logic            pipe_wr;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] load_val;
   logic [XLEN-1:0] pipe_val;

   logic [4:0]      rd_mem   [Q_DEPTH];
   logic [XLEN-1:0] data_mem [Q_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             full, empty, enq, deq, bypass;

   logic            rf_we_q, rf_we_d;
   logic [4:0]      rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
   logic            rf_src_q, rf_src_d;

   logic unused_inst;
   assign unused_inst = ^{inst_wb[31:12], inst_wb[6:0]};

   assign rd      = inst_wb[11:7];
   assign pipe_wr = valid_wb && (wb_sel != 2'b00) && (rd != 5'd0);
   assign shifted = data_in_wb >> {alu_result_wb[OFF_W-1:0], 3'b000};

   always_comb begin
      load_val = '0;
      case (memdata_width)
         3'b000: load_val = XLEN'($signed(shifted[7:0]));
         3'b100: load_val = XLEN'(shifted[7:0]);
         3'b001: load_val = XLEN'($signed(shifted[15:0]));
         3'b101: load_val = XLEN'(shifted[15:0]);
         3'b010: load_val = XLEN'($signed(shifted[31:0]));
         // On RV32 the doubleword and unsigned-word encodings collapse to a plain word load
         3'b110: begin
            if (XLEN == 64) load_val = XLEN'(shifted[31:0]);
            else            load_val = XLEN'($signed(shifted[31:0]));
         end
         3'b011: begin
            if (XLEN == 64) load_val = shifted;
            else            load_val = XLEN'($signed(shifted[31:0]));
         end
         default: load_val = '0;
      endcase
   end

   always_comb begin
      pipe_val = '0;
      case (wb_sel)
         2'b00:   pipe_val = '0;
         2'b01:   pipe_val = alu_result_wb;
         2'b10:   pipe_val = load_val;
         default: pipe_val = pc_wb + XLEN'(4);
      endcase
   end

   assign full     = (count_q == (PTR_W + 1)'(Q_DEPTH));
   assign empty    = (count_q == '0);
   assign ll_ready = !full;

`ifdef WB_LL_BYPASS_EN
   assign bypass = empty && !pipe_wr && ll_valid;
`else
   assign bypass = 1'b0;
`endif

   assign enq = ll_valid && ll_ready && !bypass;
   assign deq = !pipe_wr && !empty;

   always_comb begin
      wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      rf_src_d   = rf_src_q;
      if (pipe_wr) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = rd;
         rf_wdata_d = pipe_val;
         rf_src_d   = 1'b0;
      end else if (bypass) begin
         rf_we_d    = (ll_rd != 5'd0);
         rf_waddr_d = ll_rd;
         rf_wdata_d = ll_data;
         rf_src_d   = 1'b1;
      end else if (deq) begin
         // rd=0 entries still drain their slot but never write
         rf_we_d    = (rd_mem[rd_ptr_q] != 5'd0);
         rf_waddr_d = rd_mem[rd_ptr_q];
         rf_wdata_d = data_mem[rd_ptr_q];
         rf_src_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         rd_mem[wr_ptr_q]   <= ll_rd;
         data_mem[wr_ptr_q] <= ll_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         rf_src_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         rf_src_q   <= rf_src_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign rf_src   = rf_src_q;
   assign q_count  = count_q;

endmodule

// File: tb/tb_wb_merge_unit.sv
// Scoreboard bench for wb_merge_unit: pipeline and long-latency expectations are queued at issue
// and popped by a monitor whenever rf_we is seen.
module tb_wb_merge_unit;

   logic        clk;
   logic        rst;
   logic        valid_wb;
   logic [63:0] pc_wb;
   logic [31:0] inst_wb;
   logic [1:0]  wb_sel;
   logic [63:0] data_in_wb;
   logic [63:0] alu_result_wb;
   logic [2:0]  memdata_width;
   logic        ll_valid;
   logic        ll_ready;
   logic [4:0]  ll_rd;
   logic [63:0] ll_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic        rf_src;
   logic [2:0]  q_count;

   wb_merge_unit dut (
      .clk           (clk),
      .rst           (rst),
      .valid_wb      (valid_wb),
      .pc_wb         (pc_wb),
      .inst_wb       (inst_wb),
      .wb_sel        (wb_sel),
      .data_in_wb    (data_in_wb),
      .alu_result_wb (alu_result_wb),
      .memdata_width (memdata_width),
      .ll_valid      (ll_valid),
      .ll_ready      (ll_ready),
      .ll_rd         (ll_rd),
      .ll_data       (ll_data),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .rf_src        (rf_src),
      .q_count       (q_count)
   );

   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] data;
   } exp_t;

   exp_t pipe_q[$];
   exp_t ll_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [4:0]  tab_rd   [5];
   logic [63:0] tab_data [5];
   int          j;
   bit          acc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Monitor: every observed write must match the head of its source's queue
   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         exp_t e;
         checks++;
         if (rf_src === 1'b1) begin
            if (ll_q.size() == 0) begin
               errors++;
               $display("FAIL ll_write_unexpected: got rd=%0d data=0x%0h, expected no write",
                        rf_waddr, rf_wdata);
            end else begin
               e = ll_q.pop_front();
               if (rf_waddr !== e.rd || rf_wdata !== e.data) begin
                  errors++;
                  $display("FAIL ll_write: got rd=%0d data=0x%0h, expected rd=%0d data=0x%0h",
                           rf_waddr, rf_wdata, e.rd, e.data);
               end
            end
         end else begin
            if (pipe_q.size() == 0) begin
               errors++;
               $display("FAIL pipe_write_unexpected: got rd=%0d data=0x%0h src=%b, expected none",
                        rf_waddr, rf_wdata, rf_src);
            end else begin
               e = pipe_q.pop_front();
               if (rf_waddr !== e.rd || rf_wdata !== e.data) begin
                  errors++;
                  $display("FAIL pipe_write: got rd=%0d data=0x%0h, expected rd=%0d data=0x%0h",
                           rf_waddr, rf_wdata, e.rd, e.data);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(output bit accepted);
      accepted = ll_valid && ll_ready;
      @(posedge clk);
      #1;
      if (accepted && !rst && ll_rd != 5'd0) ll_q.push_back({ll_rd, ll_data});
   endtask

   task automatic pipe_issue(input logic v, input logic [4:0] rd, input logic [1:0] sel,
                             input logic [2:0] f3, input logic [63:0] din,
                             input logic [63:0] alu, input logic [63:0] pc,
                             input logic [63:0] exp);
      valid_wb      = v;
      inst_wb       = {20'h0, rd, 7'h33};
      wb_sel        = sel;
      memdata_width = f3;
      data_in_wb    = din;
      alu_result_wb = alu;
      pc_wb         = pc;
      if (v && sel != 2'b00 && rd != 5'd0) pipe_q.push_back({rd, exp});
   endtask

   task automatic next_ll();
      if (j < 5) begin
         ll_valid = 1'b1;
         ll_rd    = tab_rd[j];
         ll_data  = tab_data[j];
      end else begin
         ll_valid = 1'b0;
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && (j < 5 || q_count != 3'd0); k++) begin
         step(acc);
         if (acc) begin
            j++;
            next_ll();
         end
      end
      chk("drain_empty", 64'(q_count), 64'd0);
   endtask

   localparam logic [63:0] LD = 64'h8877_6655_4433_2211;

   initial begin
      rst = 1'b1; valid_wb = 0; pc_wb = 0; inst_wb = 0; wb_sel = 0; data_in_wb = 0;
      alu_result_wb = 0; memdata_width = 0; ll_valid = 0; ll_rd = 0; ll_data = 0; j = 0;
      step(acc);
      step(acc);
      rst = 1'b0;
      chk("reset_rf_we", 64'(rf_we), 64'd0);
      chk("reset_rf_waddr", 64'(rf_waddr), 64'd0);
      chk("reset_rf_wdata", rf_wdata, 64'd0);
      chk("reset_rf_src", 64'(rf_src), 64'd0);
      chk("reset_ll_ready", 64'(ll_ready), 64'd1);
      chk("reset_q_count", 64'(q_count), 64'd0);
      step(acc);
      chk("idle_rf_we", 64'(rf_we), 64'd0);

      // Load extraction, back to back
      pipe_issue(1, 5, 2'b10, 3'b000, LD, 64'd7, 0, 64'hFFFF_FFFF_FFFF_FF88); step(acc);
      chk("lb_latency", 64'(rf_we), 64'd1);
      pipe_issue(1, 5, 2'b10, 3'b100, LD, 64'd7, 0, 64'h88);                  step(acc);
      pipe_issue(1, 5, 2'b10, 3'b010, LD, 64'd4, 0, 64'hFFFF_FFFF_8877_6655); step(acc);
      pipe_issue(1, 6, 2'b10, 3'b001, LD, 64'd2, 0, 64'h4433);                step(acc);
      pipe_issue(1, 6, 2'b10, 3'b001, LD, 64'd6, 0, 64'hFFFF_FFFF_FFFF_8877); step(acc);
      pipe_issue(1, 7, 2'b10, 3'b101, LD, 64'd6, 0, 64'h8877);                step(acc);
      pipe_issue(1, 7, 2'b10, 3'b011, LD, 64'd0, 0, LD);                      step(acc);
      pipe_issue(1, 8, 2'b10, 3'b110, LD, 64'd4, 0, 64'h8877_6655);           step(acc);
      pipe_issue(1, 8, 2'b10, 3'b111, LD, 64'd4, 0, 64'd0);                   step(acc);
      pipe_issue(1, 9, 2'b10, 3'b000, LD, 64'd1, 0, 64'h22);                  step(acc);

      // pc+4 wrap, ALU select, and non-writing slots
      pipe_issue(1, 1, 2'b11, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);       step(acc);
      chk("pc4_wrap", rf_wdata, 64'd0);
      pipe_issue(1, 31, 2'b01, 0, 0, 64'hABCD, 0, 64'hABCD);                  step(acc);
      pipe_issue(1, 3, 2'b00, 0, 0, 64'h1111, 0, 0);                          step(acc);
      chk("sel0_no_we", 64'(rf_we), 64'd0);
      chk("hold_waddr", 64'(rf_waddr), 64'd31);
      chk("hold_wdata", rf_wdata, 64'hABCD);
      pipe_issue(1, 0, 2'b01, 0, 0, 64'h2222, 0, 0);                          step(acc);
      chk("rd0_no_we", 64'(rf_we), 64'd0);
      pipe_issue(0, 4, 2'b01, 0, 0, 64'h3333, 0, 0);                          step(acc);
      chk("invalid_no_we", 64'(rf_we), 64'd0);

      // Priority: pipeline busy for 6 cycles while 5 long-latency results are offered
      for (int i = 0; i < 5; i++) begin
         tab_rd[i]   = 5'(20 + i);
         tab_data[i] = 64'h2000 + 64'(i);
      end
      j = 0;
      next_ll();
      for (int i = 0; i < 6; i++) begin
         pipe_issue(1, 5'(10 + i), 2'b01, 0, 0, 64'h100 + 64'(i), 0, 64'h100 + 64'(i));
         step(acc);
         if (acc) begin
            j++;
            next_ll();
         end
         if (i == 3) begin
            chk("prio_full_count", 64'(q_count), 64'd4);
            chk("prio_full_ready", 64'(ll_ready), 64'd0);
         end
      end
      chk("prio_accepted", 64'(j), 64'd4);
      valid_wb = 1'b0;
      step(acc);
      chk("prio_no_refill", 64'(acc), 64'd0);
      chk("prio_first_src", 64'(rf_src), 64'd1);
      chk("prio_first_rd", 64'(rf_waddr), 64'd20);
      chk("prio_count3", 64'(q_count), 64'd3);
      chk("prio_ready_back", 64'(ll_ready), 64'd1);
      drain();

      // Full boundary with a rd=0 entry in the queue
      tab_rd[0] = 5'd21; tab_rd[1] = 5'd0; tab_rd[2] = 5'd23; tab_rd[3] = 5'd24;
      tab_rd[4] = 5'd25;
      for (int i = 0; i < 5; i++) tab_data[i] = 64'h3000 + 64'(i);
      j = 0;
      next_ll();
      for (int i = 0; i < 4; i++) begin
         pipe_issue(1, 1, 2'b01, 0, 0, 64'h300 + 64'(i), 0, 64'h300 + 64'(i));
         step(acc);
         if (acc) begin
            j++;
            next_ll();
         end
      end
      chk("full_count4", 64'(q_count), 64'd4);
      valid_wb = 1'b0;
      step(acc);
      chk("full_deq_no_enq", 64'(acc), 64'd0);
      chk("full_count3", 64'(q_count), 64'd3);
      chk("full_ready_back", 64'(ll_ready), 64'd1);
      chk("full_deq_rd", 64'(rf_waddr), 64'd21);
      pipe_issue(1, 2, 2'b01, 0, 0, 64'h3FF, 0, 64'h3FF);
      step(acc);
      if (acc) begin
         j++;
         next_ll();
      end
      chk("refill_count4", 64'(q_count), 64'd4);
      chk("refill_ready", 64'(ll_ready), 64'd0);
      valid_wb = 1'b0;
      drain();

      // Reset mid-operation discards queued entries
      for (int i = 0; i < 3; i++) begin
         ll_valid = 1'b1;
         ll_rd    = 5'(11 + i);
         ll_data  = 64'h500 + 64'(i);
         pipe_issue(1, 2, 2'b01, 0, 0, 64'h600 + 64'(i), 0, 64'h600 + 64'(i));
         step(acc);
      end
      ll_valid = 1'b0;
      valid_wb = 1'b0;
      chk("pre_reset_count", 64'(q_count), 64'd3);
      rst = 1'b1;
      step(acc);
      ll_q.delete();
      rst = 1'b0;
      chk("midreset_count", 64'(q_count), 64'd0);
      chk("midreset_ready", 64'(ll_ready), 64'd1);
      chk("midreset_rf_we", 64'(rf_we), 64'd0);
      step(acc);
      chk("post_reset_no_we", 64'(rf_we), 64'd0);

      // Single long-latency result into an empty, idle block
      ll_valid = 1'b1;
      ll_rd    = 5'd9;
      ll_data  = 64'h1234;
      step(acc);
      ll_valid = 1'b0;
`ifdef WB_LL_BYPASS_EN
      chk("bypass_we", 64'(rf_we), 64'd1);
`else
      chk("ll_enq_no_we", 64'(rf_we), 64'd0);
      chk("ll_enq_count", 64'(q_count), 64'd1);
      step(acc);
      chk("ll_we", 64'(rf_we), 64'd1);
`endif
      chk("ll_waddr", 64'(rf_waddr), 64'd9);
      chk("ll_wdata", rf_wdata, 64'h1234);
      chk("ll_src", 64'(rf_src), 64'd1);
      chk("ll_count0", 64'(q_count), 64'd0);

      step(acc);
      step(acc);
      chk("pipe_q_empty", 64'(pipe_q.size()), 64'd0);
      chk("ll_q_empty", 64'(ll_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_merge_unit.md
Name: wb_merge_unit

Overview:
- Parametrised writeback stage with two result sources and one register-file write port.
  - Source 1, the in-order pipeline: performs wb_sel selection and load-data extraction.
  - Source 2, a long-latency unit (mul/div): results are buffered in a small FIFO.
- Arbitrates the two sources onto the single write port, with a registered output.
- Sits after the MEM/WB pipeline register and drives the register file write port directly.

Parameters:
- XLEN, 64, datapath width; 32 or 64 only.
- Q_DEPTH, 4, long-latency result FIFO depth; power of two, at least 2.
- PTR_W, $clog2(Q_DEPTH), FIFO pointer width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- valid_wb  input  1  pipeline writeback slot holds a real instruction.
- pc_wb  input  XLEN  PC of the writeback instruction.
- inst_wb  input  32  instruction word; rd is inst_wb[11:7].
- wb_sel  input  2  00 zero, 01 alu_result_wb, 10 load data, 11 pc_wb+4.
- data_in_wb  input  XLEN  raw aligned memory word.
- alu_result_wb  input  XLEN  ALU result; its low bits are the load byte offset.
- memdata_width  input  3  load funct3.
- ll_valid  input  1  long-latency result offered.
- ll_ready  output  1  FIFO can accept a result; equals !full.
- ll_rd  input  5  destination register of the long-latency result.
- ll_data  input  XLEN  long-latency result value.
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  5  write address (registered).
- rf_wdata  output  XLEN  write data (registered).
- rf_src  output  1  0 = pipeline, 1 = long-latency (registered).
- q_count  output  PTR_W+1  FIFO occupancy.

Behaviour:
- Reset:
  - rf_we, rf_waddr, rf_wdata and rf_src are 0.
  - FIFO pointers and q_count are 0, so ll_ready is 1.
  - Reset asserted mid-operation discards all queued entries.
- Load extraction:
  - off = alu_result_wb[log2(XLEN/8)-1:0]; shifted = data_in_wb >> (8*off).
  - Width by funct3:
    - 000 sign-extend byte; 100 zero-extend byte.
    - 001 sign-extend half; 101 zero-extend half.
    - 010 sign-extend word; 110 zero-extend word.
    - 011 full doubleword.
  - XLEN=32: 011 and 110 behave as 010.
  - The unused encoding 111 yields 0.
- pc_wb+4 wraps modulo 2^XLEN.
- pipe_wr = valid_wb && wb_sel!=00 && rd!=0. The pipeline always has priority, and the block never stalls the pipeline.
- FIFO:
  - Enqueue when ll_valid && ll_ready.
  - Dequeue when !pipe_wr && !empty.
  - Simultaneous enqueue and dequeue leaves the count unchanged.
  - When full, ll_ready=0 even if a dequeue occurs in the same cycle (no same-cycle refill).
  - Pointers wrap modulo Q_DEPTH.
  - Entries whose ll_rd=0 are enqueued, but their dequeue produces rf_we=0 and still consumes the slot.
- Output register, next-state priority:
  - If pipe_wr: rf_we=1, rf_waddr=rd, rf_wdata=selected value, rf_src=0.
  - Else if dequeue: rf_we=(head.rd!=0), rf_waddr=head.rd, rf_wdata=head.data, rf_src=1.
  - Otherwise: rf_we=0; rf_waddr, rf_wdata and rf_src hold their values.
- Latency:
  - Pipeline value reaches rf_* one cycle after it is presented.
  - A long-latency result takes at least 2 cycles (enqueue, then dequeue into the register).
- Ordering:
  - FIFO entries retire in arrival order.
  - RAW/WAW ordering between the pipeline and long-latency results is the scoreboard's responsibility. This block does no rd comparison.

Optional Feature:
- WB_LL_BYPASS_EN, when defined:
  - If the FIFO is empty, !pipe_wr and ll_valid, the result is written straight into the output register in the same cycle. Latency is 1 cycle, rf_src=1, and nothing is enqueued.
  - ll_ready is still !full.
- When undefined, every long-latency result passes through the FIFO.

Test Plan:
- Reset, then idle: rf_we=0, ll_ready=1, q_count=0; rst asserted with 3 entries queued gives q_count=0 on the next cycle.
- Load extraction, XLEN=64, data_in_wb=0x8877_6655_4433_2211, alu_result_wb[2:0]=7, wb_sel=10, rd=5:
  - funct3=000 gives rf_wdata=0xFFFF_FFFF_FFFF_FF88.
  - funct3=100 gives 0x88.
  - With off=4, funct3=010 gives 0xFFFF_FFFF_8877_6655.
- wb_sel=11, pc_wb=0xFFFF_FFFF_FFFF_FFFC: rf_wdata=0; rd=0 with wb_sel=01 gives rf_we=0.
- Priority: pipe_wr held high for 6 cycles while ll_valid offers 5 results:
  - q_count reaches 4, then ll_ready=0.
  - Once pipe_wr drops, rf_src=1 writes retire in order, one per cycle.
- Full boundary: full FIFO with pipeline idle and ll_valid=1: dequeue occurs, no enqueue that cycle, and q_count goes 4→3→4 as ll_ready returns to 1.
- WB_LL_BYPASS_EN: empty FIFO, pipeline idle, ll_rd=9, ll_data=0x1234:
  - Next cycle rf_we=1, rf_waddr=9, rf_wdata=0x1234, q_count=0.
  - With the macro undefined, the write appears one cycle later.
